// File: rtl/seg7_pkg.sv
// Shared seven-segment codes (active-low, bit 6 = a ... bit 0 = g) for the scan driver.
// The hex letter codes are only consumed when SEG7_HEX_DECODE_EN is defined.
package seg7_pkg;

    typedef logic [6:0] seg_code_t;

    localparam seg_code_t SEG_0     = 7'b0000001;
    localparam seg_code_t SEG_1     = 7'b1001111;
    localparam seg_code_t SEG_2     = 7'b0010010;
    localparam seg_code_t SEG_3     = 7'b0000110;
    localparam seg_code_t SEG_4     = 7'b1001100;
    localparam seg_code_t SEG_5     = 7'b0100100;
    localparam seg_code_t SEG_6     = 7'b1100000;
    localparam seg_code_t SEG_7     = 7'b0001111;
    localparam seg_code_t SEG_8     = 7'b0000000;
    localparam seg_code_t SEG_9     = 7'b0001100;
    localparam seg_code_t SEG_HEX_A = 7'b0001000;
    localparam seg_code_t SEG_HEX_B = 7'b1100000;
    localparam seg_code_t SEG_HEX_C = 7'b0110001;
    localparam seg_code_t SEG_HEX_D = 7'b1000010;
    localparam seg_code_t SEG_HEX_E = 7'b0110000;
    localparam seg_code_t SEG_HEX_F = 7'b0111000;
    localparam seg_code_t SEG_BLANK = 7'b1111111;
    localparam seg_code_t SEG_ERR   = 7'b1001000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low segment decoder.
// Nibbles 10..15 show hex letters when SEG7_HEX_DECODE_EN is defined, else the error glyph.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_ERR;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
`ifdef SEG7_HEX_DECODE_EN
            4'd10:   seg = SEG_HEX_A;
            4'd11:   seg = SEG_HEX_B;
            4'd12:   seg = SEG_HEX_C;
            4'd13:   seg = SEG_HEX_D;
            4'd14:   seg = SEG_HEX_E;
            4'd15:   seg = SEG_HEX_F;
`endif
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double buffering and
// leading-zero blanking. Hex letter decoding is enabled by defining SEG7_HEX_DECODE_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        div_cnt_reg, div_cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] pend_digits_reg, disp_digits_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg, disp_dp_reg;
    logic                    update_reg, update_next;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg;
    logic                    frame_done_reg;

    logic                    step;
    logic                    boundary;
    logic [3:0]              disp_nib [NUM_DIGITS];
    logic [NUM_DIGITS:0]     zero_above;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   one_hot;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;

    assign step     = (div_cnt_reg == CNT_LAST);
    assign boundary = step && (idx_reg == IDX_LAST);

    // zero_above[i] is set when digit i and every higher digit are zero.
    assign zero_above[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign disp_nib[gi]   = disp_digits_reg[4*gi +: 4];
            assign zero_above[gi] = (disp_nib[gi] == 4'd0) && zero_above[gi+1];
            assign one_hot[gi]    = (idx_reg == IDX_W'(gi));
            if (gi == 0) begin : g_units
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = lz_en && zero_above[gi];
            end
        end
    endgenerate

    assign cur_nib = disp_nib[idx_reg];

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        div_cnt_next = step ? '0 : div_cnt_reg + CNT_W'(1);
        idx_next     = idx_reg;
        if (step) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
        // A load on the boundary cycle keeps the flag set for the following frame.
        update_next  = load || (update_reg && !boundary);
        seg_next     = blank[idx_reg] ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg     <= '0;
            idx_reg         <= '0;
            pend_digits_reg <= '0;
            pend_dp_reg     <= '0;
            disp_digits_reg <= '0;
            disp_dp_reg     <= '0;
            update_reg      <= 1'b0;
            an_reg          <= '1;
            seg_reg         <= SEG_BLANK;
            dp_reg          <= 1'b1;
            frame_done_reg  <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            idx_reg     <= idx_next;
            update_reg  <= update_next;
            if (load) begin
                pend_digits_reg <= digits;
                pend_dp_reg     <= dp_in;
            end
            // Display only changes at the frame wrap, so a frame never mixes old and new data.
            if (boundary && update_reg) begin
                disp_digits_reg <= pend_digits_reg;
                disp_dp_reg     <= pend_dp_reg;
            end
            an_reg         <= ~one_hot;
            seg_reg        <= seg_next;
            dp_reg         <= ~disp_dp_reg[idx_reg];
            frame_done_reg <= boundary;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Expected hex codes follow SEG7_HEX_DECODE_EN when it is defined for the build.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S9 = 7'b0001100;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef SEG7_HEX_DECODE_EN
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;
`else
    localparam logic [6:0] SA = 7'b1001000;
    localparam logic [6:0] SF = 7'b1001000;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   digits;
    logic [3:0]    dp_in;
    logic          load;
    logic          lz_en;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_value(input logic [15:0] d, input logic [3:0] p);
        digits = d;
        dp_in  = p;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("frame_wait", {15'd0, frame_done}, 16'd1);
    endtask

    // Called with reset just released after an edge: checks the full first frame.
    task automatic first_frame();
        logic [3:0] pat;
        for (int t = 1; t <= 16; t++) begin
            tick();
            case ((t - 1) / 4)
                0:       pat = 4'b1110;
                1:       pat = 4'b1101;
                2:       pat = 4'b1011;
                default: pat = 4'b0111;
            endcase
            check($sformatf("scan_an_t%0d", t), {12'd0, an}, {12'd0, pat});
            check($sformatf("scan_fd_t%0d", t), {15'd0, frame_done}, {15'd0, (t == 16)});
            if (t == 1) begin
                check("scan_seg_t1", {9'd0, seg}, {9'd0, S0});
                check("scan_dp_t1", {15'd0, dp}, 16'd1);
            end
        end
    endtask

    // Called right after a frame_done sample; checks each digit's first cycle and the next wrap.
    task automatic show_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpn);
        logic [6:0] es;
        logic [3:0] ea;
        for (int k = 0; k < 4; k++) begin
            tick();
            case (k)
                0:       es = s0;
                1:       es = s1;
                2:       es = s2;
                default: es = s3;
            endcase
            ea = ~(4'b0001 << k);
            check($sformatf("%s_an%0d", tag, k), {12'd0, an}, {12'd0, ea});
            check($sformatf("%s_seg%0d", tag, k), {9'd0, seg}, {9'd0, es});
            check($sformatf("%s_dp%0d", tag, k), {15'd0, dp}, {15'd0, dpn[k]});
            tick_n(3);
        end
        check($sformatf("%s_fd", tag), {15'd0, frame_done}, 16'd1);
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        lz_en  = 1'b0;
        digits = 16'h0000;
        dp_in  = 4'h0;

        #2;
        check("rst_an", {12'd0, an}, 16'h000F);
        check("rst_seg", {9'd0, seg}, {9'd0, SB});
        check("rst_dp", {15'd0, dp}, 16'd1);
        check("rst_fd", {15'd0, frame_done}, 16'd0);
        tick();
        tick();
        reset = 1'b0;
        first_frame();

        // Mid-frame load must not show until the next wrap.
        tick_n(5);
        load_value(16'h1234, 4'h0);
        tick_n(3);
        check("old_d2_an", {12'd0, an}, 16'b1011);
        check("old_d2_seg", {9'd0, seg}, {9'd0, S0});
        tick_n(4);
        check("old_d3_an", {12'd0, an}, 16'b0111);
        check("old_d3_seg", {9'd0, seg}, {9'd0, S0});
        wait_frame();
        show_frame("v1234", S1, S2, S3, S4, 4'hF);

        // Leading-zero blanking; dp on a blanked digit stays lit.
        tick_n(2);
        lz_en = 1'b1;
        load_value(16'h0050, 4'b0100);
        wait_frame();
        show_frame("lz0050", SB, SB, S5, S0, 4'b1011);

        // Hex nibbles with blanking off.
        tick_n(2);
        lz_en = 1'b0;
        load_value(16'hF0A9, 4'h0);
        wait_frame();
        show_frame("hexF0A9", SF, S0, SA, S9, 4'hF);

        // Load on the boundary cycle itself.
        tick_n(3);
        load_value(16'h1111, 4'h0);
        tick_n(11);
        digits = 16'h2222;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        check("bnd_align_fd", {15'd0, frame_done}, 16'd1);
        show_frame("bnd1111", S1, S1, S1, S1, 4'hF);
        show_frame("bnd2222", S2, S2, S2, S2, 4'hF);
        show_frame("hold2222", S2, S2, S2, S2, 4'hF);

        // Asynchronous reset while digit 2 is driven; the pending load is discarded.
        load_value(16'h5555, 4'hF);
        tick_n(8);
        check("pre_rst_an", {12'd0, an}, 16'b1011);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_an", {12'd0, an}, 16'h000F);
        check("mid_rst_seg", {9'd0, seg}, {9'd0, SB});
        check("mid_rst_dp", {15'd0, dp}, 16'd1);
        check("mid_rst_fd", {15'd0, frame_done}, 16'd0);
        tick();
        check("hold_rst_an", {12'd0, an}, 16'h000F);
        reset = 1'b0;
        first_frame();
        show_frame("post_rst", S0, S0, S0, S0, 4'hF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is driven (legal >= 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port digits, input, 4*NUM_DIGITS bits: BCD nibbles, digit i at [4i+3:4i], digit 0 rightmost.
REQ-006 SHALL have port dp_in, input, NUM_DIGITS bits: decimal point request per digit, 1 = lit.
REQ-007 SHALL have port load, input, 1 bit: one-cycle strobe capturing digits/dp_in into pending register.
REQ-008 SHALL have port lz_en, input, 1 bit: 1 = leading-zero suppression enabled.
REQ-009 SHALL have port an, output, NUM_DIGITS bits: active-low digit enables, one-hot-low.
REQ-010 SHALL have port seg, output, 7 bits: active-low segments, seg[6]=a through seg[0]=g.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-013 SHALL count div_cnt 0..REFRESH_DIV-1; at terminal count wraps to 0 and scan index advances by 1.
REQ-014 SHALL wrap scan index from NUM_DIGITS-1 to 0; wrap cycle is the frame boundary.
REQ-015 SHALL, on load, copy digits/dp_in into pending register and set update flag; later load before the boundary overwrites pending.
REQ-016 SHALL at frame boundary copy pending into display register and clear update flag only if flag set; display otherwise unchanged (no mid-frame tearing).
REQ-017 SHALL, if load coincides with frame boundary, transfer the previous pending contents and keep the new capture pending for the next boundary.
REQ-018 SHALL register an/seg/dp: they reflect the new scan index one cycle after index change.
REQ-019 SHALL decode 0..9 as: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 1100000, 0001111, 0000000, 0001100.
REQ-020 SHALL decode nibbles 10..15 to 1001000 when HEX_DECODE_EN undefined.
REQ-021 SHALL, with lz_en=1, blank (seg=1111111) digit i>0 when it and all higher digits are 0; digit 0 never blanked; dp unaffected.
REQ-022 SHALL pulse frame_done high for exactly the cycle after the frame boundary.

Reset
REQ-023 SHALL on reset: div_cnt=0, index=0, an=all 1s, seg=1111111, dp=1, frame_done=0, display and pending=0, update flag=0.
REQ-024 SHALL, on reset deasserted mid-frame, restart scan at digit 0 with full REFRESH_DIV dwell; pending load lost.

Configuration
REQ-025 SHALL use macro SEG7_HEX_DECODE_EN: defined, nibbles 10..15 decode A,b,C,d,E,F = 0001000, 1100000, 0110001, 1000010, 0110000, 0111000; undefined, REQ-020 applies.

Structure
REQ-026 SHALL place segment code constants, blank code 1111111 and error code 1001000 in shared package seg7_pkg.
REQ-027 SHALL instantiate one combinational sub-module seg7_decode (4-bit in, 7-bit out, macro-aware).

Verification
REQ-028 SHALL cover: reset, REFRESH_DIV=4, NUM_DIGITS=4 -> an 1110,1101,1011,0111 each 4 cycles, frame_done every 16 cycles.
REQ-029 SHALL cover: load digits=16'h1234 mid-frame -> old value until next boundary, then digit0 seg=1001100, digit3 seg=1001111.
REQ-030 SHALL cover: lz_en=1, digits=16'h0050 -> digits 3,2 seg=1111111, digit1=0100100, digit0=0000001.
REQ-031 SHALL cover: nibble 4'hA -> seg=1001000 without SEG7_HEX_DECODE_EN, 0001000 with it.
REQ-032 SHALL cover: load on boundary cycle with 16'h1111 then 16'h2222 -> frame n shows 1111, frame n+1 shows 2222.
REQ-033 SHALL cover: reset asserted while index=2 -> an=1111, seg=1111111 immediately, scan resumes at digit 0.
